mul2_sched: RTL and testbench

Sequencer for the 3-share masked AND gadget Mul2 (3-bit shared x, y and z, 2-bit fresh randomness r). It accepts one shared operand pair per transaction and precomputes randomness into a small buffer while idle. It drives the gadget's inputs for exactly the gadget latency and then returns the shared product through a valid/ready handshake. It sits between the cipher round logic and the Mul2 instance and is the sole owner of the gadget's r input.

---
 rtl/mul2_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_mul2_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul2_sched.sv
// ---------------------------------------------------------------------------
// mul2_sched
//
// Purpose:
//   Sequencer for a 3-share masked AND gadget (Mul2). It takes one shared
//   operand pair per transaction and drives the gadget inputs for the
//   gadget latency. It then returns the shared product through a
//   valid/ready handshake. While idle it fills a small randomness FIFO
//   from a 16-bit Fibonacci LFSR. It is the only driver of the gadget's
//   r input.
//
// Parameters:
//   LAT    gadget latency in clock edges (0..7, 0 = combinational gadget)
//   DEPTH  randomness FIFO entries of 2 bits (power of two, 2..16)
//   SEED   LFSR reset value (0 is replaced by 16'hACE1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair present
//   in_ready   block can accept an operand pair
//   x_in/y_in  shares of x and y (3 bits each)
//   out_valid  z_out holds a result
//   out_ready  consumer takes the result
//   z_out      shares of z (3 bits)
//   m_x/m_y    operands driven to the gadget
//   m_r        fresh randomness driven to the gadget (2 bits)
//   m_z        product shares returned by the gadget
//   r_count    randomness entries currently buffered
//
// Build option:
//   MUL2_SCHED_PRECHARGE_EN  when defined, the gadget inputs are driven to
//                            zero for one PRE cycle after each transaction
//                            and stay zero throughout IDLE.
// ---------------------------------------------------------------------------
module mul2_sched #(
   parameter int          LAT   = 1,
   parameter int          DEPTH = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             x_in,
   input  logic [2:0]             y_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2:0]             z_out,
   output logic [2:0]             m_x,
   output logic [2:0]             m_y,
   output logic [1:0]             m_r,
   input  logic [2:0]             m_z,
   output logic [$clog2(DEPTH):0] r_count
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
   localparam logic [2:0]        LAT_C    = 3'(LAT);
   localparam logic [15:0]       SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

`ifdef MUL2_SCHED_PRECHARGE_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2,
      S_PRE   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;
`endif

   state_t             state_q;
   logic [2:0]         waitCnt_q;
   logic [2:0]         mX_q;
   logic [2:0]         mY_q;
   logic [1:0]         mR_q;
   logic [2:0]         zOut_q;
   logic               outValid_q;

   logic [15:0]        lfsr_q,  lfsr_d;
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         rBuf_q [DEPTH];

   logic               push;
   logic               pop;
   logic               accept;
   logic               feedback;
   logic [1:0]         head;

   // A transaction is accepted only from IDLE and only with at least one
   // randomness entry buffered, so the gadget always gets fresh r.
   assign in_ready = (state_q == S_IDLE) && (count_q != '0);
   assign accept   = in_ready && in_valid;

   // The generator advances whenever there is room. A pop in the same
   // cycle does not make room early: fullness is judged on the
   // registered count.
   assign push     = (count_q != FULL);
   assign pop      = accept;
   assign head     = rBuf_q[rdPtr_q];

   // Taps 16,14,13,11 of the right-shifting Fibonacci form map to
   // register bits 0,2,3,5.
   assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   // Next state of the randomness generator and FIFO bookkeeping. A
   // simultaneous push and pop leaves the occupancy unchanged.
   always_comb begin
      lfsr_d  = lfsr_q;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         lfsr_d  = {feedback, lfsr_q[15:1]};
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Randomness generator and FIFO pointer registers. Reset empties the
   // buffer and reloads the seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q  <= SEED_EFF;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         lfsr_q  <= lfsr_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // FIFO storage. Each entry holds the two low LFSR bits taken before the
   // step. Contents need no reset because the occupancy count gates reads.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         rBuf_q[wrPtr_q] <= lfsr_q[1:0];
      end
   end

   // Transaction sequencer. Gadget inputs are captured at acceptance and
   // held through ISSUE and DONE. The wait counter runs 0..LAT, so the
   // gadget output is sampled LAT+1 edges after acceptance. All outputs
   // come straight from registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         waitCnt_q  <= '0;
         mX_q       <= '0;
         mY_q       <= '0;
         mR_q       <= '0;
         zOut_q     <= '0;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  mX_q      <= x_in;
                  mY_q      <= y_in;
                  mR_q      <= head;
                  waitCnt_q <= '0;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (waitCnt_q == LAT_C) begin
                  zOut_q     <= m_z;
                  outValid_q <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  waitCnt_q <= waitCnt_q + 3'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
`ifdef MUL2_SCHED_PRECHARGE_EN
                  mX_q       <= '0;
                  mY_q       <= '0;
                  mR_q       <= '0;
                  state_q    <= S_PRE;
`else
                  state_q    <= S_IDLE;
`endif
               end
            end
`ifdef MUL2_SCHED_PRECHARGE_EN
            S_PRE: begin
               state_q <= S_IDLE;
            end
`endif
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = outValid_q;
   assign z_out     = zOut_q;
   assign m_x       = mX_q;
   assign m_y       = mY_q;
   assign m_r       = mR_q;
   assign r_count   = count_q;

endmodule

// File: tb/tb_mul2_sched.sv
// ---------------------------------------------------------------------------
// tb_mul2_sched
//
// Self-checking bench for mul2_sched with LAT=1, DEPTH=4, SEED=16'hACE1.
// A small masked-AND gadget with one register stage stands in for Mul2.
// A transaction-level model (randomness queue plus a phase variable)
// predicts every output on every cycle. Directed checks with hand-computed
// literals pin the model to known values.
// ---------------------------------------------------------------------------
module tb_mul2_sched;

   localparam int          LAT   = 1;
   localparam int          DEPTH = 4;
   localparam logic [15:0] SEED  = 16'hACE1;
`ifdef MUL2_SCHED_PRECHARGE_EN
   localparam int          MINGAP = LAT + 3;
   localparam bit          PRECHARGE = 1'b1;
`else
   localparam int          MINGAP = LAT + 2;
   localparam bit          PRECHARGE = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] x_in;
   logic [2:0] y_in;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] z_out;
   logic [2:0] m_x;
   logic [2:0] m_y;
   logic [1:0] m_r;
   logic [2:0] m_z;
   logic [2:0] r_count;

   int checks = 0;
   int errors = 0;

   mul2_sched #(
      .LAT   (LAT),
      .DEPTH (DEPTH),
      .SEED  (SEED)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z_out     (z_out),
      .m_x       (m_x),
      .m_y       (m_y),
      .m_r       (m_r),
      .m_z       (m_z),
      .r_count   (r_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Masked AND over three shares: the XOR of the result shares equals the
   // product of the XORs of the operand shares.
   function automatic logic [2:0] mul2f(input logic [2:0] x, input logic [2:0] y,
                                        input logic [1:0] r);
      logic [2:0] z;
      z[0] = (x[0] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[0]) ^ r[0];
      z[1] = (x[1] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[1]) ^ r[1];
      z[2] = (x[2] & y[2]) ^ (x[0] & y[2]) ^ (x[2] & y[0]) ^ r[0] ^ r[1];
      return z;
   endfunction

   // Stand-in gadget with a latency of one clock edge.
   logic [2:0] gadgetZ = 3'b000;
   always @(posedge clk) gadgetZ <= mul2f(m_x, m_y, m_r);
   assign m_z = gadgetZ;

   // Transaction-level reference model.
   // phase: 0 idle, 1 gadget busy, 2 result offered, 3 precharge
   int         phase = 0;
   int         busyLeft = 0;
   logic [1:0] rq[$];
   logic [15:0] mLfsr = SEED;
   logic [2:0] exMx = 3'b0, exMy = 3'b0, exZ = 3'b0;
   logic [1:0] exMr = 2'b0;
   logic       exOv = 1'b0;
   bit         mPush;
   logic [1:0] mPushVal;

   always @(posedge clk) begin
      if (rst) begin
         phase = 0;
         rq.delete();
         mLfsr = SEED;
         exMx = 3'b0; exMy = 3'b0; exMr = 2'b0; exZ = 3'b0; exOv = 1'b0;
      end else begin
         mPush    = (rq.size() < DEPTH);
         mPushVal = mLfsr[1:0];
         if (phase == 0) begin
            if (in_valid && rq.size() > 0) begin
               exMx = x_in;
               exMy = y_in;
               exMr = rq.pop_front();
               busyLeft = LAT + 1;
               phase = 1;
            end
         end else if (phase == 1) begin
            busyLeft = busyLeft - 1;
            if (busyLeft == 0) begin
               exZ = mul2f(exMx, exMy, exMr);
               exOv = 1'b1;
               phase = 2;
            end
         end else if (phase == 2) begin
            if (out_ready) begin
               exOv = 1'b0;
               if (PRECHARGE) begin
                  exMx = 3'b0; exMy = 3'b0; exMr = 2'b0;
                  phase = 3;
               end else begin
                  phase = 0;
               end
            end
         end else begin
            phase = 0;
         end
         if (mPush) begin
            rq.push_back(mPushVal);
            mLfsr = (mLfsr >> 1) | (((mLfsr ^ (mLfsr >> 2) ^ (mLfsr >> 3) ^ (mLfsr >> 5)) & 16'h1) << 15);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      checkOutput("m_in_ready",  16'(in_ready),  16'(phase == 0 && rq.size() != 0));
      checkOutput("m_out_valid", 16'(out_valid), 16'(exOv));
      checkOutput("m_z_out",     16'(z_out),     16'(exZ));
      checkOutput("m_m_x",       16'(m_x),       16'(exMx));
      checkOutput("m_m_y",       16'(m_y),       16'(exMy));
      checkOutput("m_m_r",       16'(m_r),       16'(exMr));
      checkOutput("m_r_count",   16'(r_count),   16'(rq.size()));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic iv, input logic [2:0] x, input logic [2:0] y,
                                input logic ordy);
      in_valid  = iv;
      x_in      = x;
      y_in      = y;
      out_ready = ordy;
   endtask

   // Counts edges until out_valid is seen, bounded by a cycle budget.
   task automatic waitValid(output int n);
      n = 0;
      while (n < 30) begin
         tick();
         n++;
         if (out_valid) return;
      end
      checks++;
      errors++;
      $display("[TB] FAIL wait_out_valid: got timeout, expected out_valid within 30 cycles");
   endtask

   int n;
   int lastAcc;
   int accCount;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);

      // Reset held for three cycles: everything reads zero.
      repeat (3) tick();
      checkOutput("rst_in_ready",  16'(in_ready),  16'h0);
      checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
      checkOutput("rst_z_out",     16'(z_out),     16'h0);
      checkOutput("rst_m_x",       16'(m_x),       16'h0);
      checkOutput("rst_m_y",       16'(m_y),       16'h0);
      checkOutput("rst_m_r",       16'(m_r),       16'h0);
      checkOutput("rst_r_count",   16'(r_count),   16'h0);

      // Buffer fills one entry per edge and then stops at DEPTH.
      rst = 1'b0;
      tick();
      checkOutput("fill_r_count_1", 16'(r_count),  16'd1);
      checkOutput("fill_in_ready",  16'(in_ready), 16'd1);
      repeat (3) tick();
      checkOutput("fill_r_count_4", 16'(r_count),  16'd4);
      repeat (6) tick();
      checkOutput("full_r_count",   16'(r_count),  16'd4);

      // Single transaction: x=1, y=1, product 1. The first head is ACE1[1:0]=01.
      applyStimulus(1'b1, 3'b001, 3'b111, 1'b1);
      tick();
      in_valid = 1'b0;
      checkOutput("t1_m_r",     16'(m_r),      16'h1);
      checkOutput("t1_m_x",     16'(m_x),      16'h1);
      checkOutput("t1_m_y",     16'(m_y),      16'h7);
      checkOutput("t1_in_ready", 16'(in_ready), 16'h0);
      waitValid(n);
      checkOutput("t1_latency", 16'(n), 16'(LAT + 1));
      checkOutput("t1_product", 16'(^z_out), 16'h1);
      tick();
      checkOutput("t1_handshake", 16'(out_valid), 16'h0);

      // Backpressure: x=110 (0), y=011 (0), product 0, consumer stalls.
      repeat (3) tick();
      applyStimulus(1'b1, 3'b110, 3'b011, 1'b0);
      tick();
      in_valid = 1'b0;
      waitValid(n);
      checkOutput("bp_latency", 16'(n), 16'(LAT + 1));
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_out_valid", 16'(out_valid), 16'h1);
         checkOutput("bp_in_ready",  16'(in_ready),  16'h0);
         checkOutput("bp_m_x",       16'(m_x),       16'h6);
         checkOutput("bp_product",   16'(^z_out),    16'h0);
      end
      out_ready = 1'b1;
      tick();
      checkOutput("bp_release", 16'(out_valid), 16'h0);

      // Reset while the gadget is busy: the transaction disappears.
      repeat (3) tick();
      applyStimulus(1'b1, 3'b011, 3'b101, 1'b1);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_out_valid", 16'(out_valid), 16'h0);
      checkOutput("mid_m_x",       16'(m_x),       16'h0);
      checkOutput("mid_r_count",   16'(r_count),   16'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput("mid_no_result", 16'(out_valid), 16'h0);
      end

      // Empty buffer: in_valid held through reset and release.
      rst = 1'b1;
      applyStimulus(1'b1, 3'b101, 3'b100, 1'b1);
      tick();
      checkOutput("empty_in_ready_rst", 16'(in_ready), 16'h0);
      rst = 1'b0;
      tick();
      checkOutput("empty_not_taken", 16'(m_x),      16'h0);
      checkOutput("empty_r_count",   16'(r_count),  16'd1);
      checkOutput("empty_in_ready",  16'(in_ready), 16'h1);
      tick();
      in_valid = 1'b0;
      checkOutput("empty_taken_m_x", 16'(m_x), 16'h5);
      checkOutput("empty_taken_m_r", 16'(m_r), 16'h1);
      waitValid(n);
      checkOutput("empty_latency", 16'(n), 16'(LAT + 1));
      checkOutput("empty_product", 16'(^z_out), 16'h0);
      tick();

      // Back-to-back: in_valid held high, consumer always ready.
      applyStimulus(1'b1, 3'b111, 3'b001, 1'b1);
      lastAcc  = -1;
      accCount = 0;
      for (int c = 0; c < 40; c++) begin
         if (in_ready && in_valid) begin
            if (lastAcc >= 0) begin
               checkOutput("b2b_gap_ok", 16'(c - lastAcc >= MINGAP), 16'h1);
            end
            lastAcc = c;
            accCount++;
         end
`ifdef MUL2_SCHED_PRECHARGE_EN
         if (in_ready) begin
            checkOutput("pre_idle_m_x", 16'(m_x), 16'h0);
            checkOutput("pre_idle_m_y", 16'(m_y), 16'h0);
            checkOutput("pre_idle_m_r", 16'(m_r), 16'h0);
         end
`endif
         tick();
         if (out_valid) begin
            checkOutput("b2b_product", 16'(^z_out), 16'h1);
         end
      end
      checkOutput("b2b_accepts", 16'(accCount >= 2), 16'h1);
      in_valid = 1'b0;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
